// File: rtl/aoi2222_arb4_if.sv
// aoi2222_arb4_if
// Bundles the shared-bus arbitration signals between the requesters and the
// aoi2222_arb4 arbiter. Clock and reset are kept as plain module ports.
//   EN      - arbitration enable (gates new grants only)
//   REQ     - per-requester level request
//   LAST    - per-requester final-transfer flag (owner only)
//   GNT     - registered one-hot grant, drives aoi2222 select inputs
//   GNT_VLD - registered OR of GNT
//   OWNER   - index of current or most recent owner
//   TIMEOUT - one-cycle pulse when the burst limit revokes a grant
// Modports: master = requester side, slave = arbiter side.
interface aoi2222_arb4_if;
  logic       EN;
  logic [3:0] REQ;
  logic [3:0] LAST;
  logic [3:0] GNT;
  logic       GNT_VLD;
  logic [1:0] OWNER;
  logic       TIMEOUT;

  modport master (
    output EN, REQ, LAST,
    input  GNT, GNT_VLD, OWNER, TIMEOUT
  );

  modport slave (
    input  EN, REQ, LAST,
    output GNT, GNT_VLD, OWNER, TIMEOUT
  );
endinterface

// File: rtl/aoi2222_arb4.sv
// aoi2222_arb4
// Registered 4-way round-robin arbiter producing the one-hot select lines for
// an aoi2222-based shared-bus mux. At most one grant is ever active, and every
// ownership change passes through at least one all-zero cycle so the inverted
// bus never combines two sources. Grants are limited to MAXBURST consecutive
// cycles (0 = unlimited).
// Ports:
//   CLK   - rising-edge clock
//   RST_N - synchronous active-low reset
//   bus   - arbitration interface (slave modport): EN, REQ, LAST in;
//           GNT, GNT_VLD, OWNER, TIMEOUT out (all registered)
// Parameters:
//   MAXBURST - max consecutive grant cycles per ownership, 0 = unlimited
//   CW       - burst counter width, MAXBURST must fit in CW bits
module aoi2222_arb4 #(
  parameter int unsigned MAXBURST = 16,
  parameter int unsigned CW       = 5
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  aoi2222_arb4_if.slave        bus
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state_q;
  logic [3:0]      gnt_q;
  logic            gnt_vld_q;
  logic [1:0]      owner_q;
  logic            timeout_q;
  logic [1:0]      ptr_q;
  logic [CW-1:0]   cnt_q;

  // Round-robin pick: first requester at or after ptr_q, wrapping mod 4.
  logic [1:0]      sel;
  logic            found;
  logic [1:0]      idx;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && bus.REQ[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  // Release conditions for the current owner.
  logic owner_req;
  logic owner_last;
  logic at_limit;
  logic release_now;
  logic limit_only;

  always_comb begin
    owner_req   = bus.REQ[owner_q];
    owner_last  = bus.LAST[owner_q];
    at_limit    = (MAXBURST != 0) && (cnt_q == CW'(MAXBURST));
    release_now = !owner_req || owner_last || at_limit;
    // A REQ drop or LAST at the limit is a normal release, not a timeout.
    limit_only  = at_limit && owner_req && !owner_last;
  end

  // With a burst limit the counter saturates; unlimited mode lets it wrap
  // since it never participates in a release decision there.
  logic [CW-1:0] cnt_inc;

  always_comb begin
    cnt_inc = cnt_q + 1'b1;
    if ((MAXBURST != 0) && (cnt_q == '1))
      cnt_inc = cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_vld_q <= 1'b0;
      owner_q   <= '0;
      timeout_q <= 1'b0;
      ptr_q     <= '0;
      cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (bus.EN && found) begin
            state_q   <= GRANT;
            gnt_q     <= 4'b0001 << sel;
            gnt_vld_q <= 1'b1;
            owner_q   <= sel;
            cnt_q     <= CW'(1);
          end else begin
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
          end
        end

        GRANT: begin
          if (release_now) begin
            // Returning to IDLE provides the mandatory all-zero turnaround.
            state_q   <= IDLE;
            gnt_q     <= '0;
            gnt_vld_q <= 1'b0;
            ptr_q     <= owner_q + 2'd1;
            timeout_q <= limit_only;
          end else begin
            cnt_q     <= cnt_inc;
            timeout_q <= 1'b0;
          end
        end

        default: begin
          state_q   <= IDLE;
          gnt_q     <= '0;
          gnt_vld_q <= 1'b0;
          timeout_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.GNT     = gnt_q;
  assign bus.GNT_VLD = gnt_vld_q;
  assign bus.OWNER   = owner_q;
  assign bus.TIMEOUT = timeout_q;

endmodule

// File: tb/tb_aoi2222_arb4.sv
// tb_aoi2222_arb4
// Directed bench for aoi2222_arb4 with MAXBURST=4. Each step drives inputs,
// queues the expected registered outputs for the following cycle, then pops
// and compares them one time unit after the clock edge.
module tb_aoi2222_arb4;

  logic CLK;
  logic RST_N;

  aoi2222_arb4_if bus ();

  aoi2222_arb4 #(
    .MAXBURST (4),
    .CW       (5)
  ) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       tmo;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic step(input string tag, input logic rst_n_v, input logic en_v,
                      input logic [3:0] req_v, input logic [3:0] last_v,
                      input logic [3:0] e_gnt, input logic [1:0] e_owner,
                      input logic e_tmo);
    exp_t e;
    RST_N    = rst_n_v;
    bus.EN   = en_v;
    bus.REQ  = req_v;
    bus.LAST = last_v;
    e.tag   = tag;
    e.gnt   = e_gnt;
    e.owner = e_owner;
    e.tmo   = e_tmo;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    checks++;
    assert (bus.GNT === e.gnt) else begin
      errors++;
      $error("FAIL %s gnt observed=%b expected=%b", e.tag, bus.GNT, e.gnt);
    end
    checks++;
    assert (bus.GNT_VLD === (|e.gnt)) else begin
      errors++;
      $error("FAIL %s gnt_vld observed=%b expected=%b", e.tag, bus.GNT_VLD, |e.gnt);
    end
    checks++;
    assert (bus.OWNER === e.owner) else begin
      errors++;
      $error("FAIL %s owner observed=%0d expected=%0d", e.tag, bus.OWNER, e.owner);
    end
    checks++;
    assert (bus.TIMEOUT === e.tmo) else begin
      errors++;
      $error("FAIL %s timeout observed=%b expected=%b", e.tag, bus.TIMEOUT, e.tmo);
    end
    checks++;
    assert ($onehot0(bus.GNT)) else begin
      errors++;
      $error("FAIL %s onehot observed=%b expected=onehot0", e.tag, bus.GNT);
    end
  endtask

  initial begin
    RST_N    = 1'b0;
    bus.EN   = 1'b0;
    bus.REQ  = 4'b1111;
    bus.LAST = 4'b0000;

    // Reset held three cycles with all requests pending.
    step("rst0", 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step("rst1", 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step("rst2", 1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0);

    // Round robin, LAST on the second grant cycle of each owner.
    step("rr_g0a", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rr_g0b", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rr_t0",  1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0);
    step("rr_g1a", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("rr_g1b", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("rr_t1",  1'b1, 1'b1, 4'b1111, 4'b0010, 4'b0000, 2'd1, 1'b0);
    step("rr_g2a", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("rr_g2b", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("rr_t2",  1'b1, 1'b1, 4'b1111, 4'b0100, 4'b0000, 2'd2, 1'b0);
    step("rr_g3a", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
    step("rr_g3b", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b1000, 2'd3, 1'b0);
    step("rr_t3",  1'b1, 1'b1, 4'b1111, 4'b1000, 4'b0000, 2'd3, 1'b0);
    step("rr_wrap", 1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rr_rel0", 1'b1, 1'b1, 4'b1111, 4'b0001, 4'b0000, 2'd0, 1'b0);

    // Burst limit: requester 2 alone, LAST low.
    step("to_c1", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("to_c2", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("to_c3", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("to_c4", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("to_pulse", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0000, 2'd2, 1'b1);
    step("to_regrant", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);

    // LAST coinciding with the limit suppresses TIMEOUT.
    step("ll_c2", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("ll_c3", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("ll_c4", 1'b1, 1'b1, 4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b0);
    step("ll_rel", 1'b1, 1'b1, 4'b0100, 4'b0100, 4'b0000, 2'd2, 1'b0);

    // EN gating in IDLE, then EN dropped during an active grant.
    step("en_off0", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd2, 1'b0);
    step("en_off1", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd2, 1'b0);
    step("en_on",   1'b1, 1'b1, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("en_hold1", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("en_hold2", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b0);
    step("en_reqdrop", 1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0);
    step("en_block0", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0);
    step("en_block1", 1'b1, 1'b0, 4'b0010, 4'b0000, 4'b0000, 2'd1, 1'b0);

    // Reset in grant cycle 2 of requester 3; pointer must return to 0.
    step("mr_g1", 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    step("mr_g2", 1'b1, 1'b1, 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b0);
    step("mr_rst", 1'b0, 1'b1, 4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0);
    step("mr_ptr0", 1'b1, 1'b1, 4'b1001, 4'b0000, 4'b0001, 2'd0, 1'b0);

    // REQ drop at the limit is a normal release without TIMEOUT.
    step("rd_c2", 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rd_c3", 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rd_c4", 1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b0);
    step("rd_rel", 1'b1, 1'b1, 4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/aoi2222_arb4.md
# aoi2222_arb4

Registered 4-way round-robin arbiter that generates the one-hot select pairs for an aoi2222-based N-bit shared-bus mux in the ARM datapath. Per requester i, the instantiator replicates GNT[i] across N bits onto the aoi2222 select input, with data on the paired input. The arbiter guarantees at most one select is ever active and inserts a one-cycle all-zero turnaround between owners, so the inverted bus never ORs two sources. It also enforces a maximum burst length per grant.

## Interface
- MAXBURST, 16, max consecutive grant cycles per ownership; 0 = unlimited.
- CW, 5, burst counter width; MAXBURST <= 2^CW-1 is required.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  reset, synchronous, active-low; the only clock is CLK.
- EN  input  1  arbitration enable; gates new grants only.
- REQ  input  4  per-requester request, level.
- LAST  input  4  per-requester final-transfer flag, sampled only for the current owner.
- GNT  output  4  registered one-hot grant; drives the aoi2222 select inputs.
- GNT_VLD  output  1  OR of GNT, registered.
- OWNER  output  2  index of the current or most recent owner.
- TIMEOUT  output  1  one-cycle pulse when a grant is revoked by the burst limit.

## Operation
- All outputs are registered. There is no combinational path from inputs to outputs.
- State machine has two states, IDLE and GRANT. Internal state: PTR[1:0] (round-robin start index) and CNT[CW-1:0].
- Reset values (RST_N low at a CLK edge): state=IDLE, GNT=0, GNT_VLD=0, OWNER=0, TIMEOUT=0, PTR=0, CNT=0.
- IDLE:
  - If EN=1 and REQ!=0, select the first i with REQ[i]=1, searching PTR, PTR+1, PTR+2, PTR+3 (mod 4).
  - Then set GNT=1<<i, OWNER=i, CNT=1, and go to GRANT.
  - Otherwise stay in IDLE with GNT=0.
- GRANT, owner o, CNT=k (k-th cycle that GNT is high):
  - Release if REQ[o]=0, or if REQ[o]=1 and LAST[o]=1, or if MAXBURST!=0 and k==MAXBURST.
  - Otherwise CNT=k+1 and GNT is held.
- On release:
  - Next cycle GNT=0 and state=IDLE.
  - PTR=o+1 mod 4; the wrap 3 to 0 is required.
  - OWNER keeps o.
  - TIMEOUT=1 for that one cycle only when the burst limit is the sole release cause. LAST or a REQ drop at k==MAXBURST takes precedence, and no TIMEOUT is generated.
- Turnaround: after any release, IDLE lasts at least one cycle with GNT=0, even if other requests are pending. This gives a minimum 1-cycle gap between owners.
- EN=0 blocks only new grants in IDLE. A grant in progress runs to its normal release.
- REQ of non-owners is ignored in GRANT. LAST of non-owners is ignored always.
- The CNT saturation path is not reachable when MAXBURST is legal. With MAXBURST=0, CNT wraps freely and never causes a release.
- Invariant: GNT is 0 or exactly one-hot in every cycle, including the reset cycle.

## Timing
- Grant latency: REQ sampled high at edge t in IDLE gives GNT high after edge t (visible in cycle t+1).
- Release latency: a release condition sampled at edge t gives GNT=0 in cycle t+1. The earliest next grant is cycle t+2.
- Maximum grant length is MAXBURST cycles. The worst-case wait for a requester is 3*(MAXBURST+1) cycles.
- RST_N low mid-grant: at that edge GNT drops to 0, TIMEOUT=0, and PTR=0. No TIMEOUT is generated and no turnaround is owed.
- GNT_VLD equals |GNT in every cycle.

## Test plan
- Reset/idle: hold RST_N=0 3 cycles with REQ=4'b1111, then RST_N=1 and EN=1.
  - Required: GNT=0 during reset; GNT=4'b0001 in the 2nd cycle after release; OWNER=0.
- Round-robin: REQ=4'b1111 held, LAST asserted on the 2nd grant cycle of each owner.
  - Required: GNT sequence 0001,0001,0000,0010,0010,0000,0100,0100,0000,1000,1000,0000,0001 (wrap).
- Timeout: MAXBURST=4, REQ=4'b0100 held, LAST=0.
  - Required: GNT=0100 for exactly 4 cycles, then GNT=0 with TIMEOUT=1 for 1 cycle, then GNT=0100 again.
- LAST on limit: MAXBURST=4, LAST[2]=1 in grant cycle 4.
  - Required: GNT drops and TIMEOUT stays 0.
- EN gating: EN=0 with REQ=4'b0010.
  - Required: GNT stays 0.
  - Then drop EN during an active grant to requester 1. Required: the grant continues until REQ[1] falls, and no new grant follows while EN=0.
- Reset mid-grant: RST_N=0 in grant cycle 2 of requester 3.
  - Required: GNT=0 and PTR=0 next cycle; after RST_N=1 with REQ=4'b1001, requester 0 is granted first.
